// File: rtl/rr_xbar_router.sv
// ----------------------------------------------------------------------------
// rr_xbar_router
//   NUM_PORTS input FIFOs share one transfer channel into NUM_PORTS output
//   registers. A round-robin arbiter moves at most one word per cycle; the
//   word's top DEST_W bits select the output register it lands in. All
//   handshakes are valid/ready, so an all-zero word is ordinary payload.
//
// Ports
//   clk_i        clock, all logic on posedge
//   reset_i      synchronous, active-high
//   in_data_i    NUM_PORTS*DATA_W, port i = [i*DATA_W +: DATA_W]
//   in_valid_i   word present on input i
//   in_ready_o   FIFO i can accept (not full)
//   out_data_o   NUM_PORTS*DATA_W output registers
//   out_valid_o  output register j holds a word
//   out_ready_i  sink j consumes a word this cycle
//   fifo_full_o  FIFO i full (status)
//   grant_id_o   input granted in the most recent transfer
// ----------------------------------------------------------------------------

// Per-input FIFO. Pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
module rr_xbar_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic                          do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // Full refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

module rr_xbar_router #(
    parameter int DATA_W     = 10,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    output logic [NUM_PORTS-1:0]          in_ready_o,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    output logic [NUM_PORTS-1:0]          fifo_full_o,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id_o
);
    localparam int DEST_W = $clog2(NUM_PORTS);

    typedef struct packed {
        logic              vld;
        logic [DEST_W-1:0] idx;   // winning input
        logic [DEST_W-1:0] dst;   // output slot it targets
        logic [DATA_W-1:0] word;
    } gnt_t;

    logic [NUM_PORTS-1:0][DATA_W-1:0] in_words, head;
    logic [NUM_PORTS-1:0]             full, empty, push, pop, elig, slot_free;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_PORTS-1:0]             out_valid_q, out_valid_d;
    logic [DEST_W-1:0]                ptr_q, ptr_d, grant_q, grant_d, idx;
    gnt_t                             gnt;

    assign in_words = in_data_i;
    assign push     = in_valid_i & ~full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        rr_xbar_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .data_i  (in_words[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    // A slot can take a new word if empty or being drained this cycle.
    assign slot_free = ~out_valid_q | out_ready_i;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            elig[i] = !empty[i] && slot_free[head[i][DATA_W-1 -: DEST_W]];
    end

    // Scan upward from the pointer; index arithmetic wraps at NUM_PORTS
    // because NUM_PORTS is a power of two.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_q + DEST_W'(k);
            if (!gnt.vld && elig[idx]) begin
                gnt.vld = 1'b1;
                gnt.idx = idx;
            end
        end
        gnt.word = head[gnt.idx];
        gnt.dst  = gnt.word[DATA_W-1 -: DEST_W];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            pop[i] = gnt.vld && (gnt.idx == DEST_W'(i));
    end

    // Consumed slots clear unless reloaded by this cycle's grant.
    always_comb begin
        out_valid_d = out_valid_q & ~out_ready_i;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        if (gnt.vld) begin
            out_valid_d[gnt.dst] = 1'b1;
            out_data_d[gnt.dst]  = gnt.word;
            ptr_d                = gnt.idx + DEST_W'(1);
            grant_d              = gnt.idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
        end
    end

    assign in_ready_o  = ~full;
    assign fifo_full_o = full;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign grant_id_o  = grant_q;
endmodule

// File: tb/tb_rr_xbar_router.sv
module tb_rr_xbar_router;
    localparam int DW = 10, NP = 4, FD = 4, DESTW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NP*DW-1:0]     in_data, out_data;
    logic [NP-1:0]        in_valid, in_ready, out_valid, out_ready, fifo_full;
    logic [DESTW-1:0]     grant_id;

    rr_xbar_router #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .fifo_full_o (fifo_full),
        .grant_id_o  (grant_id)
    );

    int total = 0, bad = 0;

    // Reference model: each input FIFO is a queue, each output slot a
    // valid flag; exp_q holds words per output in the order they must appear.
    logic [DW-1:0]    mq    [NP][$];
    logic [DW-1:0]    exp_q [NP][$];
    logic [NP-1:0]    m_ov  = '0;
    logic [DESTW-1:0] m_gid = '0;
    int               m_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs the DUT saw.
    task automatic model_step();
        logic [NP-1:0] acc;
        logic [DW-1:0] w;
        int            g, i, d;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                exp_q[p].delete();
            end
            m_ov = '0; m_gid = '0; m_ptr = 0;
            return;
        end
        for (int p = 0; p < NP; p++) acc[p] = in_valid[p] && (mq[p].size() < FD);
        g = -1;
        for (int k = 0; k < NP; k++) begin
            i = (m_ptr + k) % NP;
            if (g < 0 && mq[i].size() > 0) begin
                w = mq[i][0];
                d = int'(w[DW-1 -: DESTW]);
                if (!m_ov[d] || out_ready[d]) g = i;
            end
        end
        m_ov = m_ov & ~out_ready;
        if (g >= 0) begin
            w = mq[g].pop_front();
            d = int'(w[DW-1 -: DESTW]);
            m_ov[d] = 1'b1;
            exp_q[d].push_back(w);
            m_gid = DESTW'(g);
            m_ptr = (g + 1) % NP;
        end
        for (int p = 0; p < NP; p++)
            if (acc[p]) mq[p].push_back(in_data[p*DW +: DW]);
    endtask

    task automatic cyc(input logic [NP-1:0] v, input logic [NP*DW-1:0] d,
                       input logic [NP-1:0] r, input logic rs);
        in_valid = v; in_data = d; out_ready = r; reset = rs;
        @(posedge clk); #1;
        model_step();
    endtask

    // Monitor: status against the model, consumed words against the scoreboard.
    always @(negedge clk) begin
        logic [NP-1:0] mrdy;
        for (int p = 0; p < NP; p++) mrdy[p] = (mq[p].size() < FD);
        check("status", 64'({out_valid, in_ready, fifo_full, grant_id}),
                        64'({m_ov, mrdy, ~mrdy, m_gid}));
        for (int j = 0; j < NP; j++) begin
            if (out_valid[j] && out_ready[j]) begin
                if (exp_q[j].size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected out%0d: got %0h expected none", j, out_data[j*DW +: DW]);
                end else begin
                    check($sformatf("sb_data out%0d", j), 64'(out_data[j*DW +: DW]), 64'(exp_q[j].pop_front()));
                end
            end
        end
    end

    logic [NP*DW-1:0] rd;

    initial begin
        // 1. reset
        cyc('0, '0, '0, 1'b1);
        cyc('0, '0, '0, 1'b1);
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst out_data", 64'(out_data), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'hF);
        check("rst grant_id", 64'(grant_id), 64'h0);
        check("rst fifo_full", 64'(fifo_full), 64'h0);

        // 2. route in0 -> out2
        cyc(4'b0001, {10'h0, 10'h0, 10'h0, 10'h2AB}, 4'h0, 1'b0);
        cyc('0, '0, 4'h0, 1'b0);
        check("route out_valid", 64'(out_valid), 64'b0100);
        check("route data", 64'(out_data[2*DW +: DW]), 64'h2AB);
        check("route grant", 64'(grant_id), 64'h0);

        // 3. all-zero payload from in3 -> out0
        cyc(4'b1000, '0, 4'hF, 1'b0);
        cyc('0, '0, 4'h0, 1'b0);
        check("zero valid0", 64'(out_valid[0]), 64'h1);
        check("zero data0", 64'(out_data[0 +: DW]), 64'h0);
        check("zero grant", 64'(grant_id), 64'h3);
        cyc('0, '0, 4'hF, 1'b0);

        // 4. round robin, all inputs to out1
        cyc(4'hF, {10'h103, 10'h102, 10'h101, 10'h100}, 4'hF, 1'b0);
        for (int g = 0; g < NP; g++) begin
            cyc('0, '0, 4'hF, 1'b0);
            check("rr grant", 64'(grant_id), 64'(g));
            check("rr data1", 64'(out_data[DW +: DW]), 64'(10'h100 + g));
            check("rr valid1", 64'(out_valid[1]), 64'h1);
        end
        cyc('0, '0, 4'hF, 1'b0);

        // 5. backpressure on out1, in0 streams
        for (int k = 0; k < 5; k++) cyc(4'b0001, 40'(10'h140 + k), 4'b1101, 1'b0);
        check("bp full", 64'(fifo_full[0]), 64'h1);
        check("bp ready", 64'(in_ready[0]), 64'h0);
        cyc(4'b0001, 40'(10'h1FF), 4'b1101, 1'b0);
        cyc(4'b0001, 40'(10'h1FF), 4'b1101, 1'b0);
        check("bp held valid", 64'(out_valid[1]), 64'h1);
        check("bp held data", 64'(out_data[DW +: DW]), 64'h140);
        check("bp still full", 64'(fifo_full[0]), 64'h1);
        for (int k = 0; k < 7; k++) cyc('0, '0, 4'hF, 1'b0);
        check("bp drained", 64'({out_valid, fifo_full}), 64'h0);

        // 6. mid-run reset with data queued everywhere
        for (int k = 0; k < 3; k++)
            cyc(4'hF, {10'h3C0 + 10'(k), 10'h280 + 10'(k), 10'h1A0 + 10'(k), 10'h050 + 10'(k)}, 4'h0, 1'b0);
        cyc('0, '0, 4'h0, 1'b1);
        check("mrst out_valid", 64'(out_valid), 64'h0);
        check("mrst out_data", 64'(out_data), 64'h0);
        check("mrst in_ready", 64'(in_ready), 64'hF);
        check("mrst grant", 64'(grant_id), 64'h0);
        for (int k = 0; k < 4; k++) cyc('0, '0, 4'hF, 1'b0);

        // Random traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            for (int p = 0; p < NP; p++) rd[p*DW +: DW] = DW'($urandom);
            cyc(NP'($urandom), rd, NP'($urandom | $urandom), ($urandom_range(0, 199) == 0));
        end

        // Drain and confirm every expected word appeared
        for (int k = 0; k < 24; k++) cyc('0, '0, 4'hF, 1'b0);
        for (int j = 0; j < NP; j++) check($sformatf("leftover out%0d", j), 64'(exp_q[j].size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
